// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Round-robin scheduler that shares one UART transmit path among N character
// sources. A winner's character and parity select are captured into din/p_s.
// The frame is then launched through the transmit controller's send/busy
// handshake. The winner gets a one-cycle grant, and a done pulse is raised
// when the frame finishes.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req          per-requester request level, held until granted
//   req_data     character for requester i at [i*DATA_W +: DATA_W]
//   req_ps       parity-select bit per requester
//   busy         busy from the transmit controller
//   send         start request to the transmit controller
//   din          captured character, changes only on grant edges
//   p_s          captured parity select, registered with din
//   grant        one-hot single-cycle pulse, requester's data captured
//   done         single-cycle pulse, granted frame finished (busy fell)
//   err_timeout  single-cycle pulse, busy never rose during launch
//   cur_id       index of requester owning the transmitter
//   active       high in LAUNCH, WAIT and GAP
module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int DATA_W     = 7,
  parameter int LAUNCH_TO  = 16,
  parameter int GAP_CYCLES = 2,
  localparam int ID_W      = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N*DATA_W-1:0] req_data,
  input  logic [N-1:0]        req_ps,
  input  logic                busy,
  output logic                send,
  output logic [DATA_W-1:0]   din,
  output logic                p_s,
  output logic [N-1:0]        grant,
  output logic                done,
  output logic                err_timeout,
  output logic [ID_W-1:0]     cur_id,
  output logic                active
);

  // One counter serves both the launch timeout and the inter-frame gap.
  localparam int CNT_MAX = (LAUNCH_TO > GAP_CYCLES) ? LAUNCH_TO : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] LAUNCH_LAST = CNT_W'(LAUNCH_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ID_W-1:0]   ptr_reg, ptr_next;

  logic              send_reg, send_next;
  logic [DATA_W-1:0] din_reg, din_next;
  logic              ps_reg, ps_next;
  logic [N-1:0]      grant_reg, grant_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [ID_W-1:0]   cur_id_reg, cur_id_next;
  logic              active_reg, active_next;

  // Unpack the flat data bus into one entry per requester.
  logic [DATA_W-1:0] data_arr [N];
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Round-robin pick: first set request at or after the pointer, wrapping.
  // idx is one bit wider than the pointer so ptr + k (< 2N) cannot overflow.
  logic            any_req;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] winner_inc;
  logic [ID_W:0]   idx;

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N)) begin
        idx = idx - (ID_W+1)'(N);
      end
      if (!any_req && req[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[ID_W-1:0];
      end
    end
  end

  assign winner_inc = (winner == ID_W'(N - 1)) ? '0 : winner + ID_W'(1);

  logic launch_expired;
  assign launch_expired = (cnt_reg == LAUNCH_LAST);

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      ptr_reg    <= '0;
      send_reg   <= 1'b0;
      din_reg    <= '0;
      ps_reg     <= 1'b0;
      grant_reg  <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
      cur_id_reg <= '0;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ptr_reg    <= ptr_next;
      send_reg   <= send_next;
      din_reg    <= din_next;
      ps_reg     <= ps_next;
      grant_reg  <= grant_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      cur_id_reg <= cur_id_next;
      active_reg <= active_next;
    end
  end

  // Next-state logic. busy seen in IDLE or GAP is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          state_next = S_LAUNCH;
          cnt_next   = '0;
          // Advances on every grant, even one that later times out.
          ptr_next   = winner_inc;
        end
      end
      S_LAUNCH: begin
        if (busy) begin
          state_next = S_WAIT;
        end else if (launch_expired) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (!busy) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end
      end
      S_GAP: begin
        if (cnt_reg == GAP_LAST) begin
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: values the output registers take on the coming edge.
  always_comb begin
    send_next   = 1'b0;
    grant_next  = '0;
    done_next   = 1'b0;
    err_next    = 1'b0;
    din_next    = din_reg;
    ps_next     = ps_reg;
    cur_id_next = cur_id_reg;
    active_next = (state_next != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          send_next   = 1'b1;
          grant_next  = N'(1) << winner;
          din_next    = data_arr[winner];
          ps_next     = req_ps[winner];
          cur_id_next = winner;
        end
      end
      S_LAUNCH: begin
        send_next = !busy && !launch_expired;
        err_next  = !busy && launch_expired;
      end
      S_WAIT: begin
        done_next = !busy;
      end
      default: begin
      end
    endcase
  end

  assign send        = send_reg;
  assign din         = din_reg;
  assign p_s         = ps_reg;
  assign grant       = grant_reg;
  assign done        = done_reg;
  assign err_timeout = err_reg;
  assign cur_id      = cur_id_reg;
  assign active      = active_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ps = '0;
  logic          busy = 1'b0;
  logic          send;
  logic [DW-1:0] din;
  logic          p_s;
  logic [N-1:0]  grant;
  logic          done;
  logic          err_timeout;
  logic [1:0]    cur_id;
  logic          active;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  uart_tx_arbiter #(
    .N(N), .DATA_W(DW), .LAUNCH_TO(16), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_ps(req_ps),
    .busy(busy), .send(send), .din(din), .p_s(p_s), .grant(grant),
    .done(done), .err_timeout(err_timeout), .cur_id(cur_id), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance n clocks; returns 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic set_slice(input int i, input logic [DW-1:0] d, input logic ps);
    req_data[i*DW +: DW] = d;
    req_ps[i] = ps;
  endtask

  task automatic check_grant(input string tag, input logic [N-1:0] g, input logic [DW-1:0] d,
                             input logic ps, input logic [1:0] id);
    $display("grant %s: grant=%b din=%h p_s=%0b cur_id=%0d", tag, grant, din, p_s, cur_id);
    check_val({tag, "_grant"}, 32'(grant), 32'(g));
    check_val({tag, "_din"}, 32'(din), 32'(d));
    check_val({tag, "_ps"}, 32'(p_s), 32'(ps));
    check_val({tag, "_id"}, 32'(cur_id), 32'(id));
    check_val({tag, "_send"}, 32'(send), 32'h1);
    check_val({tag, "_act"}, 32'(active), 32'h1);
  endtask

  // Called right after a grant edge. busy is first sampled high on the
  // edge 'delay' cycles after grant and stays high for 'len' edges.
  // Returns after the gap, with the arbiter back in IDLE.
  task automatic run_frame(input string tag, input int delay, input int len);
    if (delay > 1) begin
      tick(1);
      check_val({tag, "_grant_1cyc"}, 32'(grant), 32'h0);
      tick(delay - 2);
      check_val({tag, "_send_pre"}, 32'(send), 32'h1);
    end
    busy = 1'b1;
    tick(1);
    check_val({tag, "_send_drop"}, 32'(send), 32'h0);
    for (int j = 1; j < len; j++) begin
      tick(1);
      check_val({tag, "_act_wait"}, 32'(active), 32'h1);
    end
    busy = 1'b0;
    tick(1);
    check_val({tag, "_done"}, 32'(done), 32'h1);
    check_val({tag, "_done_grant"}, 32'(grant), 32'h0);
    check_val({tag, "_done_err"}, 32'(err_timeout), 32'h0);
    tick(1);
    check_val({tag, "_done_1cyc"}, 32'(done), 32'h0);
    check_val({tag, "_gap_act"}, 32'(active), 32'h1);
    tick(1);
    check_val({tag, "_idle_act"}, 32'(active), 32'h0);
    $display("frame %s finished at cycle %0d", tag, cyc);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
  endtask

  initial begin
    int prev_g;
    // Reset state
    #1;
    check_val("rst_send", 32'(send), 32'h0);
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_active", 32'(active), 32'h0);
    check_val("rst_din", 32'(din), 32'h0);
    check_val("rst_done_err", 32'({done, err_timeout, p_s, cur_id}), 32'h0);
    tick(2);
    rst = 1'b1;
    tick(1);

    // Single request from requester 1
    set_slice(1, 7'h03, 1'b1);
    req = 4'b0010;
    tick(1);
    check_grant("single", 4'b0010, 7'h03, 1'b1, 2'd1);
    req = 4'b0000;
    run_frame("single", 2, 80);

    // Round robin with all requesters held, pointer starting at 0
    do_reset();
    for (int i = 0; i < N; i++) set_slice(i, 7'(8'h10 + 8'(i)), (i % 2) == 0);
    req = 4'b1111;
    tick(1);
    prev_g = cyc;
    for (int i = 0; i < 5; i++) begin
      int w;
      w = i % N;
      if (i > 0) begin
        tick(1);
        check_val("rr_spacing", 32'(cyc - prev_g), 32'd10);
        prev_g = cyc;
      end
      check_grant("rr", 4'(1 << w), 7'(8'h10 + 8'(w)), (w % 2) == 0, 2'(w));
      run_frame("rr", 2, 5);
    end

    // Pointer wrap: pointer is now 1; requester 3 then 0 then 2
    req = 4'b1000;
    tick(1);
    check_grant("wrap3", 4'b1000, 7'h13, 1'b0, 2'd3);
    req = 4'b0101;
    run_frame("wrap3", 2, 3);
    tick(1);
    check_grant("wrap0", 4'b0001, 7'h10, 1'b1, 2'd0);
    run_frame("wrap0", 2, 3);
    tick(1);
    check_grant("wrap2", 4'b0100, 7'h12, 1'b1, 2'd2);
    req = 4'b0000;
    run_frame("wrap2", 2, 3);

    // Timeout: busy never rises; pointer 3 -> requester 0 wins
    set_slice(0, 7'h55, 1'b0);
    set_slice(1, 7'h2a, 1'b1);
    req = 4'b0001;
    tick(1);
    check_grant("tmo", 4'b0001, 7'h55, 1'b0, 2'd0);
    req = 4'b0011;
    for (int j = 1; j < 16; j++) begin
      tick(1);
      check_val("tmo_send_hold", 32'({send, err_timeout}), 32'h2);
    end
    tick(1);
    check_val("tmo_send_drop", 32'(send), 32'h0);
    check_val("tmo_err", 32'(err_timeout), 32'h1);
    check_val("tmo_no_done", 32'(done), 32'h0);
    tick(1);
    check_val("tmo_err_1cyc", 32'(err_timeout), 32'h0);
    check_val("tmo_no_done2", 32'(done), 32'h0);
    tick(1);
    check_val("tmo_idle", 32'(active), 32'h0);
    tick(1);
    check_grant("tmo_next", 4'b0010, 7'h2a, 1'b1, 2'd1);
    req = 4'b0000;
    run_frame("tmo_next", 1, 3);

    // Reset during WAIT; pointer was 2
    set_slice(2, 7'h7f, 1'b1);
    req = 4'b0100;
    tick(1);
    check_grant("rstmid", 4'b0100, 7'h7f, 1'b1, 2'd2);
    req = 4'b0000;
    tick(1);
    busy = 1'b1;
    tick(2);
    check_val("rstmid_wait", 32'({send, active}), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check_val("rstmid_send", 32'(send), 32'h0);
    check_val("rstmid_active", 32'(active), 32'h0);
    check_val("rstmid_gd", 32'({grant, done, err_timeout}), 32'h0);
    check_val("rstmid_data", 32'({din, p_s, cur_id}), 32'h0);
    busy = 1'b0;
    tick(1);
    check_val("rstmid_held", 32'({send, active, done}), 32'h0);
    rst = 1'b1;
    set_slice(3, 7'h21, 1'b0);
    req = 4'b1000;
    tick(1);
    check_grant("after_rst", 4'b1000, 7'h21, 1'b0, 2'd3);
    req = 4'b0000;
    run_frame("after_rst", 2, 3);

    // Spurious busy in IDLE
    busy = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick(1);
      check_val("spur_outs", 32'({send, grant, done, err_timeout, active}), 32'h0);
    end
    busy = 1'b0;
    tick(1);
    check_val("spur_no_done", 32'({done, active}), 32'h0);
    tick(1);
    check_val("spur_idle", 32'({send, grant, done, err_timeout, active}), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
